sum_accum: RTL and testbench
============================

Name: sum_accum

Overview:
- Downstream consumer of the registered 16+16 adder stage.
- Takes a stream of 17-bit sums and accumulates blocks of 2^N_LOG2 samples.
- Each completed (or flushed) block total, its sample count and its block average go into a small first-word-fall-through result FIFO, drained by a valid/ready handshake.
- Decouples adder throughput from the slower result consumer (UART/display logic).

Parameters:
- IN_W, 17, width of incoming sum (adder result width).
- N_LOG2, 3, log2 of samples per block (block = 8 samples).
- FIFO_DEPTH, 4, result FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data carries a sample this cycle.
- in_data  input  IN_W  unsigned sum from adder stage.
- in_ready  output  1  block can accept a sample this cycle.
- flush  input  1  single-cycle pulse; close current partial block.
- out_valid  output  1  FIFO head entry valid.
- out_ready  input  1  consumer takes head entry this cycle.
- out_sum  output  IN_W+N_LOG2  block total, unsigned, never overflows.
- out_cnt  output  N_LOG2+1  samples in the entry (1..2^N_LOG2).
- out_avg  output  IN_W  out_sum >> N_LOG2 if out_cnt == 2^N_LOG2, else 0.
- fifo_full  output  1  FIFO holds FIFO_DEPTH entries.

Behaviour:
- Reset (async, reset_n low):
  - Accumulator, sample counter, flush_pend, FIFO pointers and count cleared.
  - Outputs: out_valid=0, out_sum=0, out_cnt=0, out_avg=0, fifo_full=0.
  - in_ready follows fifo_full, so in_ready=1 during reset.
  - Reset mid-block discards the partial block and all FIFO contents, with no output.
- Acceptance: sample taken when in_valid && in_ready; in_ready = !fifo_full (combinational from the registered count).
- Accumulation:
  - acc width IN_W+N_LOG2.
  - On accept: acc <= acc + in_data, cnt <= cnt + 1.
  - The 2^N_LOG2-th accepted sample completes the block.
- Completion: the FIFO entry is written at the same edge the last sample is accepted.
  - Entry contents: sum = acc + in_data, cnt = 2^N_LOG2, avg = sum >> N_LOG2.
  - acc and cnt return to 0 at that edge.
  - out_valid rises the next cycle if the FIFO was empty: latency 1 cycle from last-sample acceptance.
- Flush: flush is captured into flush_pend and is serviced when the FIFO is not full.
  - Service with cnt>0 and no same-cycle sample: push {acc, cnt, avg=0}; clear acc and cnt.
  - Service with a same-cycle accepted sample: that sample is included first.
    - If it completes the block, push a normal full entry.
    - Otherwise push the partial entry with cnt+1.
    - One entry only.
  - Service with cnt=0 and no sample: no push; flush_pend is cleared.
  - Flush while the FIFO is full: flush_pend stays set; serviced on the first cycle the FIFO is not full.
  - Further flush pulses while pending merge.
- FIFO:
  - First-word fall-through; out_* driven from registered head storage.
  - Pop on out_valid && out_ready.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Pointers wrap modulo FIFO_DEPTH.
  - Pop from empty is impossible (out_valid=0).
  - Push when full is impossible by construction (in_ready=0, flush held).
- Handshake rules:
  - out_sum, out_cnt and out_avg stay stable while out_valid && !out_ready.
  - in_ready may drop only as a result of a push; it is never a function of in_valid.
- Width: the maximum total (2^IN_W - 1)·2^N_LOG2 fits IN_W+N_LOG2 bits; there is no saturation or overflow logic.

Test Plan:
- Reset then 8 accepted samples of 0x1FFFE, out_ready=1 -> one entry one cycle after the 8th: out_sum=0xFFFF0, out_cnt=8, out_avg=0x1FFFE; acc back to 0.
- Samples 1,2,3 then flush pulse -> entry out_sum=6, out_cnt=3, out_avg=0; the next block starts from 0.
- out_ready=0, stream 40 samples of 0x00010 -> 4 entries (sum 0x80, avg 0x10 each), fifo_full=1, in_ready=0 after 32 accepted; the remaining samples are held upstream.
- Then out_ready=1 -> entries drain in order, in_ready returns.
- FIFO full with 3 samples in acc, flush pulse, then one pop -> flush_pend serviced the cycle after the pop: entry cnt=3 appended last.
- Assert reset_n low mid-block (5 samples) and with 2 FIFO entries -> out_valid=0 immediately.
  - After release, 8 samples of 1 give out_sum=8, out_cnt=8, out_avg=1.
- Simultaneous pop and 8th-sample push with 1 entry present -> count stays 1, new head correct next cycle.

Source files
------------

// File: rtl/sum_accum.sv
// Block accumulator behind the registered adder stage: sums blocks of 2^N_LOG2
// samples and queues {total, count, average} in a first-word-fall-through FIFO.
module sum_accum #(
    parameter int unsigned IN_W       = 17,
    parameter int unsigned N_LOG2     = 3,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    input  logic [IN_W-1:0]        in_data,
    output logic                   in_ready,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [IN_W+N_LOG2-1:0] out_sum,
    output logic [N_LOG2:0]        out_cnt,
    output logic [IN_W-1:0]        out_avg,
    output logic                   fifo_full
);

    localparam int unsigned SUM_W = IN_W + N_LOG2;
    localparam int unsigned CNT_W = N_LOG2 + 1;
    localparam int unsigned BLOCK = 1 << N_LOG2;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    typedef struct packed {
        logic [SUM_W-1:0] sum;
        logic [CNT_W-1:0] cnt;
        logic [IN_W-1:0]  avg;
    } entry_t;

    logic [SUM_W-1:0] acc;
    logic [SUM_W-1:0] sum_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             flush_pend;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;
    logic [OCC_W-1:0] occ_nxt;
    logic             accept;
    logic             service;
    logic             push;
    logic             pop;
    entry_t           wr_entry;
    entry_t           head;
    entry_t           mem [FIFO_DEPTH];

    assign in_ready = !fifo_full;

    // Block bookkeeping: a pending flush and the current sample fold into one entry.
    always_comb begin
        accept   = in_valid && in_ready;
        service  = flush_pend && !fifo_full;
        sum_nxt  = acc + (accept ? SUM_W'(in_data) : SUM_W'(0));
        cnt_nxt  = cnt + (accept ? CNT_W'(1) : CNT_W'(0));
        push     = (cnt_nxt == CNT_W'(BLOCK)) || (service && (cnt_nxt != CNT_W'(0)));
        pop      = out_valid && out_ready;
        occ_nxt  = occ + OCC_W'(push) - OCC_W'(pop);
        wr_entry.sum = sum_nxt;
        wr_entry.cnt = cnt_nxt;
        wr_entry.avg = (cnt_nxt == CNT_W'(BLOCK)) ? IN_W'(sum_nxt >> N_LOG2) : IN_W'(0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc        <= '0;
            cnt        <= '0;
            flush_pend <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ        <= '0;
            out_valid  <= 1'b0;
            fifo_full  <= 1'b0;
        end else begin
            if (push) begin
                acc <= '0;
                cnt <= '0;
            end else if (accept) begin
                acc <= sum_nxt;
                cnt <= cnt_nxt;
            end
            flush_pend <= flush || (flush_pend && !service);
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            occ       <= occ_nxt;
            out_valid <= (occ_nxt != OCC_W'(0));
            fifo_full <= (occ_nxt == OCC_W'(FIFO_DEPTH));
        end
    end

    // Payload storage needs no reset; the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_comb begin
        head    = mem[rd_ptr];
        out_sum = out_valid ? head.sum : SUM_W'(0);
        out_cnt = out_valid ? head.cnt : CNT_W'(0);
        out_avg = out_valid ? head.avg : IN_W'(0);
    end

endmodule

// File: tb/tb_sum_accum.sv
// Scoreboard bench for sum_accum: a block-level model predicts FIFO entries,
// a separate monitor compares them as the DUT presents them.
module tb_sum_accum;

    localparam int IN_W  = 17;
    localparam int NL    = 3;
    localparam int BLOCK = 8;
    localparam int DEPTH = 4;

    typedef struct {
        logic [IN_W+NL-1:0] sum;
        logic [NL:0]        cnt;
        logic [IN_W-1:0]    avg;
    } exp_t;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               in_valid;
    logic [IN_W-1:0]    in_data;
    logic               in_ready;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic [IN_W+NL-1:0] out_sum;
    logic [NL:0]        out_cnt;
    logic [IN_W-1:0]    out_avg;
    logic               fifo_full;

    int vectors = 0;
    int errors  = 0;

    exp_t            exp_q[$];
    logic [IN_W-1:0] part[$];
    int              occ  = 0;
    bit              pend = 0;

    sum_accum #(.IN_W(IN_W), .N_LOG2(NL), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cnt(out_cnt), .out_avg(out_avg), .fifo_full(fifo_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: samples of the open block are kept as a list; an entry is
    // the plain sum of that list, produced when it reaches BLOCK or a flush is served.
    always @(negedge clk) begin
        bit   acc_ok, pop, service, pushed;
        exp_t e;
        if (!reset_n) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_sum", out_sum, 0);
            chk("rst_out_cnt", out_cnt, 0);
            chk("rst_out_avg", out_avg, 0);
            chk("rst_fifo_full", fifo_full, 0);
            chk("rst_in_ready", in_ready, 1);
            occ = 0;
            pend = 0;
            part.delete();
            exp_q.delete();
        end else begin
            chk("in_ready", in_ready, occ < DEPTH);
            chk("out_valid", out_valid, occ != 0);
            chk("fifo_full", fifo_full, occ == DEPTH);
            acc_ok  = in_valid && (occ < DEPTH);
            pop     = (occ != 0) && out_ready;
            service = pend && (occ < DEPTH);
            pushed  = 0;
            if (acc_ok) part.push_back(in_data);
            if (part.size() == BLOCK || (service && part.size() != 0)) begin
                e.sum = '0;
                foreach (part[i]) e.sum += part[i];
                e.cnt = (NL+1)'(part.size());
                e.avg = (part.size() == BLOCK) ? IN_W'(e.sum / BLOCK) : '0;
                exp_q.push_back(e);
                part.delete();
                pushed = 1;
            end
            pend = flush || (pend && !service);
            occ  = occ + int'(pushed) - int'(pop);
        end
    end

    // Monitor: the presented head must always equal the oldest predicted entry.
    always @(negedge clk) begin
        if (reset_n && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_entry", 1, 0);
            end else begin
                chk("out_sum", out_sum, exp_q[0].sum);
                chk("out_cnt", out_cnt, exp_q[0].cnt);
                chk("out_avg", out_avg, exp_q[0].avg);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    // Offer n samples of value v; each waits (bounded) until the DUT takes it.
    task automatic send(input logic [IN_W-1:0] v, input int n);
        for (int k = 0; k < n; k++) begin
            bit taken;
            int waited = 0;
            in_valid = 1'b1;
            in_data  = v;
            do begin
                taken = in_ready;
                tick();
                waited++;
            end while (!taken && waited < 200);
            if (!taken) chk("send_timeout", 0, 1);
        end
        in_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        // Full-scale block and a flushed partial block.
        out_ready = 1'b1;
        send(17'h1FFFE, 8);
        idle(3);
        send(17'd1, 1); send(17'd2, 1); send(17'd3, 1);
        pulse_flush();
        idle(3);

        // Fill the FIFO, stall upstream, flush while full, then drain.
        out_ready = 1'b0;
        send(17'h10, 32);
        in_valid = 1'b1; in_data = 17'h10;
        repeat (5) tick();
        in_valid = 1'b0;
        pulse_flush();
        idle(2);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        idle(3);
        out_ready = 1'b1;
        send(17'h10, 8);
        idle(8);

        // Flush pending while full with a sample arriving in the service cycle.
        out_ready = 1'b0;
        send(17'h21, 32);
        pulse_flush();
        in_valid = 1'b1; in_data = 17'h5;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        repeat (2) tick();
        in_valid = 1'b0;
        out_ready = 1'b1;
        idle(8);

        // Reset with two entries queued and five samples in the open block.
        out_ready = 1'b0;
        send(17'd7, 16);
        send(17'd9, 5);
        reset_n = 1'b0;
        #1;
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_out_cnt", out_cnt, 0);
        tick(); tick();
        reset_n = 1'b1;
        out_ready = 1'b1;
        send(17'd1, 8);
        idle(3);

        // Pop and eighth-sample push in the same cycle with one entry present.
        out_ready = 1'b0;
        send(17'd5, 8);
        send(17'd6, 7);
        out_ready = 1'b1;
        send(17'd6, 1);
        out_ready = 1'b0;
        idle(3);
        out_ready = 1'b1;
        idle(3);

        // Randomised traffic.
        for (int c = 0; c < 1500; c++) begin
            in_valid  = ($urandom % 4) != 0;
            in_data   = IN_W'($urandom);
            flush     = ($urandom % 16) == 0;
            out_ready = ($urandom % 3) != 0;
            tick();
        end
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        pulse_flush();
        idle(20);
        chk("drained_entries_left", exp_q.size(), 0);
        chk("final_out_valid", out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
